// File: rtl/aes_key_expand_if.sv
// ----------------------------------------------------------------------------
// aes_key_expand_if
//   Request / round-key stream bundle for the iterative AES key-schedule
//   generator.
//
//   Signals:
//     start       expansion request (sampled only while the generator is idle)
//     key_len     00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved
//     cipher_key  key, byte i at [8i+7:8i]
//     rk_data     round key, same byte ordering
//     rk_index    round number of rk_data
//     rk_valid    rk_data / rk_index valid
//     rk_ready    consumer accepts the current round key
//     busy        expansion in progress
//     done        one-cycle pulse after the final round key is accepted
//     err         one-cycle pulse when a start request is rejected
//
//   Modports: master = requester / round-key consumer, slave = generator.
// ----------------------------------------------------------------------------
interface aes_key_expand_if #(
  parameter int unsigned RK_IDX_W = 4
);
  logic                start;
  logic [1:0]          key_len;
  logic [255:0]        cipher_key;
  logic [127:0]        rk_data;
  logic [RK_IDX_W-1:0] rk_index;
  logic                rk_valid;
  logic                rk_ready;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, key_len, cipher_key, rk_ready,
    input  rk_data, rk_index, rk_valid, busy, done, err
  );

  modport slave (
    input  start, key_len, cipher_key, rk_ready,
    output rk_data, rk_index, rk_valid, busy, done, err
  );
endinterface

// File: rtl/aes_key_expand.sv
// ----------------------------------------------------------------------------
// aes_key_expand
//   Iterative AES key-schedule generator for 128/192/256-bit keys (runtime
//   selectable, bounded by KEY_MAX). One 32-bit schedule word is produced per
//   cycle; every four words form a round key that is streamed to the round
//   datapath over a valid/ready handshake, round keys 0..Nr in order.
//
//   Parameters:
//     KEY_MAX   largest key size accepted (128, 192 or 256)
//     RK_IDX_W  width of rk_index
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   aes_key_expand_if.slave (start/key_len/cipher_key in,
//           rk_data/rk_index/rk_valid out, rk_ready in, busy/done/err out)
//
//   Build option:
//     AES_KEY_ZEROIZE_EN  when defined, key material (window, assembly and
//                         output registers) is wiped on completion and
//                         rk_data reads zero whenever rk_valid is low.
//
//   Also contains aes_sbox, the forward AES S-box used by SubWord.
// ----------------------------------------------------------------------------

// Forward AES S-box, single byte, purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];
endmodule

module aes_key_expand #(
  parameter int unsigned KEY_MAX  = 256,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]          state;
  logic [31:0]         win [8];     // win[0] = w[i-Nk] ... win[Nk-1] = w[i-1]
  logic [31:0]         asm_w [3];   // first three words of the round key being built
  logic [1:0]          asm_cnt;
  logic [5:0]          word_i;
  logic [2:0]          phase;       // i mod Nk
  logic                key_pass;    // i < Nk
  logic [7:0]          rcon;
  logic [1:0]          len_q;
  logic [127:0]        rk_q;
  logic                rk_valid_q;
  logic [RK_IDX_W-1:0] rk_index_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                key_len_ok;
  logic [2:0]          nk_m1;
  logic [5:0]          last_i;
  logic [31:0]         prev_w;
  logic [31:0]         sub_in;
  logic [31:0]         sub_out;
  logic [31:0]         temp;
  logic [31:0]         new_w;
  logic                accept;
  logic                gen;
  logic                load_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    unique case (bus.key_len)
      2'd0:    key_len_ok = (KEY_MAX >= 128);
      2'd1:    key_len_ok = (KEY_MAX >= 192);
      2'd2:    key_len_ok = (KEY_MAX >= 256);
      default: key_len_ok = 1'b0;
    endcase
  end

  always_comb begin
    unique case (len_q)
      2'd0: begin
        nk_m1  = 3'd3;
        last_i = 6'd43;
        prev_w = win[3];
      end
      2'd1: begin
        nk_m1  = 3'd5;
        last_i = 6'd51;
        prev_w = win[5];
      end
      default: begin
        nk_m1  = 3'd7;
        last_i = 6'd59;
        prev_w = win[7];
      end
    endcase
  end

  // RotWord in this byte order is a right rotate by one byte.
  assign sub_in = (phase == 3'd0) ? {prev_w[7:0], prev_w[31:8]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = prev_w;
    if (phase == 3'd0)
      temp = sub_out ^ {24'h0, rcon};
    else if (len_q == 2'd2 && phase == 3'd4)
      temp = sub_out;
  end

  // During the key pass the window is rotated rather than shifted, so after
  // Nk words it again holds key words 0..Nk-1 in order and the same shift
  // rule serves every word.
  assign new_w = key_pass ? win[0] : (win[0] ^ temp);

  assign accept   = rk_valid_q && bus.rk_ready;
  assign gen      = (state == EXPAND) && !(asm_cnt == 2'd3 && rk_valid_q && !bus.rk_ready);
  assign load_out = gen && (asm_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
      for (int unsigned k = 0; k < 3; k++) asm_w[k] <= '0;
      asm_cnt    <= '0;
      word_i     <= '0;
      phase      <= '0;
      key_pass   <= 1'b0;
      rcon       <= 8'h01;
      len_q      <= '0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;

      if (accept) rk_index_q <= rk_index_q + RK_IDX_W'(1);

      if (load_out)    rk_valid_q <= 1'b1;
      else if (accept) rk_valid_q <= 1'b0;

      if (gen) begin
        for (int unsigned k = 0; k < 7; k++)
          win[k] <= (k == 32'(nk_m1)) ? new_w : win[k+1];
        win[7] <= new_w;

        // The fourth word bypasses the assembly register straight into the
        // output, so a round key is presented on the edge its last word is made.
        if (asm_cnt == 2'd3) begin
          rk_q    <= {new_w, asm_w[2], asm_w[1], asm_w[0]};
          asm_cnt <= '0;
        end else begin
          asm_w[0] <= asm_w[1];
          asm_w[1] <= asm_w[2];
          asm_w[2] <= new_w;
          asm_cnt  <= asm_cnt + 2'd1;
        end

        word_i <= word_i + 6'd1;
        if (phase == nk_m1) begin
          phase    <= '0;
          key_pass <= 1'b0;
        end else begin
          phase <= phase + 3'd1;
        end
        if (!key_pass && phase == 3'd0) rcon <= xtime(rcon);
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (key_len_ok) begin
              for (int unsigned k = 0; k < 8; k++) win[k] <= bus.cipher_key[32*k +: 32];
              word_i     <= '0;
              phase      <= '0;
              key_pass   <= 1'b1;
              rcon       <= 8'h01;
              asm_cnt    <= '0;
              len_q      <= bus.key_len;
              rk_index_q <= '0;
              busy_q     <= 1'b1;
              state      <= EXPAND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        EXPAND: begin
          if (gen && word_i == last_i) state <= DRAIN;
        end
        DRAIN: begin
          if (accept) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
`ifdef AES_KEY_ZEROIZE_EN
          for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
          for (int unsigned k = 0; k < 3; k++) asm_w[k] <= '0;
          rk_q <= '0;
`endif
        end
      endcase
    end
  end

`ifdef AES_KEY_ZEROIZE_EN
  assign bus.rk_data = rk_valid_q ? rk_q : '0;
`else
  assign bus.rk_data = rk_q;
`endif
  assign bus.rk_index = rk_index_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expand_if #(.RK_IDX_W(4)) ifa ();
  aes_key_expand_if #(.RK_IDX_W(4)) ifb ();

  aes_key_expand #(.KEY_MAX(256), .RK_IDX_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  aes_key_expand #(.KEY_MAX(128), .RK_IDX_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Upper bits of the shorter keys carry junk that must be ignored.
  localparam logic [255:0] KEY128 = {128'hdeadbeef_cafef00d_12345678_9abcdef0,
                                     128'h0f0e0d0c0b0a09080706050403020100};
  localparam logic [255:0] KEY192 = {64'h5555aaaa_33cc33cc,
                                     192'h1716151413121110_0f0e0d0c0b0a0908_0706050403020100};
  localparam logic [255:0] KEY256 = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_rk  [0:14];
  logic [127:0] got_rk  [0:19];
  logic [3:0]   got_idx [0:19];
  int           got_n   [0:19];
  int n_hs, first_valid_n, done_n, done_cnt, err_cnt, stab_bad, busy_bad;

  // ---------------- reference model (computed S-box, textbook schedule) -----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] p, r;
    p = v; r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_ref(input logic [31:0] t);
    return {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
  endfunction

  task automatic build_model(input logic [1:0] len, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * int'(len);
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw_ref({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_ref(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // ---------------- run driver: collects handshakes, no checking -----------
  task automatic run_key(input logic [1:0] len, input logic [255:0] key,
                         input bit rnd_ready, input bit poke_start);
    int n;
    logic pv, pr;
    logic [127:0] pd;
    n_hs = 0; first_valid_n = -1; done_n = -1; done_cnt = 0;
    err_cnt = 0; stab_bad = 0; busy_bad = 0;
    for (int k = 0; k < 20; k++) begin got_rk[k] = '0; got_idx[k] = '0; got_n[k] = -1; end
    @(negedge clk);
    ifa.key_len = len; ifa.cipher_key = key; ifa.start = 1'b1; ifa.rk_ready = 1'b1;
    @(posedge clk);                      // T0
    @(negedge clk);
    ifa.start = 1'b0; ifa.key_len = ~len; ifa.cipher_key = ~key;
    n = 0; pv = 1'b0; pr = 1'b1; pd = '0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ifa.err) err_cnt++;
      if (ifa.done) begin done_cnt++; done_n = n; end
      if (!ifa.busy && !ifa.done) busy_bad++;
      if (pv && !pr && (!ifa.rk_valid || ifa.rk_data !== pd)) stab_bad++;
      if (ifa.rk_valid && first_valid_n < 0) first_valid_n = n;
      ifa.start = poke_start && (n == 10);
      if (poke_start && n == 10) begin ifa.key_len = 2'b11; ifa.cipher_key = KEY256; end
      ifa.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ifa.rk_valid && ifa.rk_ready && n_hs < 20) begin
        got_rk[n_hs] = ifa.rk_data; got_idx[n_hs] = ifa.rk_index; got_n[n_hs] = n;
        n_hs++;
      end
      pv = ifa.rk_valid; pr = ifa.rk_ready; pd = ifa.rk_data;
    end
    ifa.rk_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ifa.done) done_cnt++;
      if (ifa.busy) busy_bad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    #3;
    n_cmp++; if (ifa.rk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rk_valid: got %b want 0", ifa.rk_valid); end
    n_cmp++; if (ifa.rk_data !== 128'h0) begin n_bad++; $display("FAIL reset_rk_data: got %h want 0", ifa.rk_data); end
    n_cmp++; if (ifa.rk_index !== 4'h0) begin n_bad++; $display("FAIL reset_rk_index: got %0d want 0", ifa.rk_index); end
    n_cmp++; if ({ifa.busy, ifa.done, ifa.err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {ifa.busy, ifa.done, ifa.err}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_key128;
    logic [127:0] k0;
    k0 = KEY128[127:0];
    build_model(2'b00, KEY128);
    run_key(2'b00, KEY128, 1'b0, 1'b0);
    n_cmp++; if (n_hs != 11) begin n_bad++; $display("FAIL k128_count: got %0d want 11", n_hs); end
    n_cmp++; if (first_valid_n != 4) begin n_bad++; $display("FAIL k128_first_valid: got T%0d want T4", first_valid_n); end
    n_cmp++; if (got_rk[0] !== k0) begin n_bad++; $display("FAIL k128_rk0: got %h want %h", got_rk[0], k0); end
    n_cmp++; if (got_rk[1] !== 128'hfe76abd6f178a6dafa72afd2fd74aad6) begin n_bad++; $display("FAIL k128_rk1: got %h want fe76abd6f178a6dafa72afd2fd74aad6", got_rk[1]); end
    n_cmp++; if (got_rk[10] !== 128'hc5302b4d8ba707f3174a94e37f1d1113) begin n_bad++; $display("FAIL k128_rk10: got %h want c5302b4d8ba707f3174a94e37f1d1113", got_rk[10]); end
    for (int r = 0; r <= 10; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL k128_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
      n_cmp++; if (got_idx[r] !== 4'(r)) begin n_bad++; $display("FAIL k128_idx[%0d]: got %0d want %0d", r, got_idx[r], r); end
      n_cmp++; if (got_n[r] != 4 * (r + 1)) begin n_bad++; $display("FAIL k128_time[%0d]: got T%0d want T%0d", r, got_n[r], 4 * (r + 1)); end
    end
    n_cmp++; if (done_n != 45) begin n_bad++; $display("FAIL k128_done_time: got T%0d want T45", done_n); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL k128_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL k128_busy: got %0d bad cycles want 0", busy_bad); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL k128_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_key192;
    build_model(2'b01, KEY192);
    run_key(2'b01, KEY192, 1'b0, 1'b0);
    n_cmp++; if (n_hs != 13) begin n_bad++; $display("FAIL k192_count: got %0d want 13", n_hs); end
    n_cmp++; if (got_rk[12] !== 128'h5d1da4e371c218c409dc781a330a97a4) begin n_bad++; $display("FAIL k192_rk12: got %h want 5d1da4e371c218c409dc781a330a97a4", got_rk[12]); end
    for (int r = 0; r <= 12; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL k192_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
      n_cmp++; if (got_idx[r] !== 4'(r)) begin n_bad++; $display("FAIL k192_idx[%0d]: got %0d want %0d", r, got_idx[r], r); end
    end
    n_cmp++; if (done_n != 4 * 13 + 1) begin n_bad++; $display("FAIL k192_done_time: got T%0d want T53", done_n); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL k192_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_key256;
    build_model(2'b10, KEY256);
    run_key(2'b10, KEY256, 1'b0, 1'b0);
    n_cmp++; if (n_hs != 15) begin n_bad++; $display("FAIL k256_count: got %0d want 15", n_hs); end
    n_cmp++; if (got_rk[14] !== 128'h36de686d3cc21a37e97909bfcc79fc24) begin n_bad++; $display("FAIL k256_rk14: got %h want 36de686d3cc21a37e97909bfcc79fc24", got_rk[14]); end
    for (int r = 0; r <= 14; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL k256_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
    end
    n_cmp++; if (done_n != 61) begin n_bad++; $display("FAIL k256_done_time: got T%0d want T61", done_n); end
  endtask

  task automatic test_backpressure;
    build_model(2'b10, KEY256);
    run_key(2'b10, KEY256, 1'b1, 1'b0);
    n_cmp++; if (n_hs != 15) begin n_bad++; $display("FAIL bp_count: got %0d want 15", n_hs); end
    for (int r = 0; r <= 14; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL bp_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
      n_cmp++; if (got_idx[r] !== 4'(r)) begin n_bad++; $display("FAIL bp_idx[%0d]: got %0d want %0d", r, got_idx[r], r); end
    end
    n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored;
    build_model(2'b01, KEY192);
    run_key(2'b01, KEY192, 1'b0, 1'b1);
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL busy_start_err: got %0d want 0", err_cnt); end
    n_cmp++; if (n_hs != 13) begin n_bad++; $display("FAIL busy_start_count: got %0d want 13", n_hs); end
    for (int r = 0; r <= 12; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL busy_start_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
    end
  endtask

  task automatic test_err;
    int seen_valid, seen_busy, n;
    logic [127:0] k0;
    k0 = KEY128[127:0];
    @(negedge clk);
    ifa.key_len = 2'b11; ifa.cipher_key = KEY256; ifa.start = 1'b1;
    @(posedge clk); @(negedge clk);
    ifa.start = 1'b0;
    n_cmp++; if (ifa.err !== 1'b1) begin n_bad++; $display("FAIL err_reserved: got %b want 1", ifa.err); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("FAIL err_reserved_busy: got %b want 0", ifa.busy); end
    @(negedge clk);
    n_cmp++; if (ifa.err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width: got %b want 0", ifa.err); end
    seen_valid = 0; seen_busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifa.rk_valid) seen_valid++;
      if (ifa.busy) seen_busy++;
    end
    n_cmp++; if (seen_valid != 0) begin n_bad++; $display("FAIL err_no_valid: got %0d want 0", seen_valid); end
    n_cmp++; if (seen_busy != 0) begin n_bad++; $display("FAIL err_no_busy: got %0d want 0", seen_busy); end

    for (int t = 0; t < 2; t++) begin
      ifb.key_len = (t == 0) ? 2'b10 : 2'b01; ifb.cipher_key = KEY256; ifb.start = 1'b1;
      @(posedge clk); @(negedge clk);
      ifb.start = 1'b0;
      n_cmp++; if ({ifb.err, ifb.busy} !== 2'b10) begin n_bad++; $display("FAIL kmax128_reject[%0d]: got err,busy=%b want 10", t, {ifb.err, ifb.busy}); end
      @(negedge clk);
    end

    ifb.key_len = 2'b00; ifb.cipher_key = KEY128; ifb.start = 1'b1;
    @(posedge clk); @(negedge clk);
    ifb.start = 1'b0;
    n_cmp++; if ({ifb.err, ifb.busy} !== 2'b01) begin n_bad++; $display("FAIL kmax128_accept: got err,busy=%b want 01", {ifb.err, ifb.busy}); end
    n = 0;
    while (!ifb.rk_valid && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (ifb.rk_data !== k0) begin n_bad++; $display("FAIL kmax128_rk0: got %h want %h", ifb.rk_data, k0); end
    n = 0;
    while (!ifb.done && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (ifb.done !== 1'b1) begin n_bad++; $display("FAIL kmax128_done: got %b want 1", ifb.done); end
    @(negedge clk);
  endtask

  task automatic test_rst_abort;
    int n, hs, seen_done, seen_busy, seen_valid;
    @(negedge clk);
    ifa.key_len = 2'b00; ifa.cipher_key = KEY128; ifa.rk_ready = 1'b1; ifa.start = 1'b1;
    @(posedge clk); @(negedge clk);
    ifa.start = 1'b0;
    n = 0; hs = 0;
    while (hs < 4 && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ifa.rk_valid && ifa.rk_ready) hs++;
    end
    n_cmp++; if (hs != 4) begin n_bad++; $display("FAIL abort_reach_rk3: got %0d handshakes want 4", hs); end
    @(posedge clk);                      // rk3 accepted here
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ifa.rk_valid, ifa.busy, ifa.done, ifa.err} !== 4'b0000) begin n_bad++; $display("FAIL abort_flags: got %b want 0000", {ifa.rk_valid, ifa.busy, ifa.done, ifa.err}); end
    n_cmp++; if (ifa.rk_index !== 4'h0) begin n_bad++; $display("FAIL abort_rk_index: got %0d want 0", ifa.rk_index); end
    n_cmp++; if (ifa.rk_data !== 128'h0) begin n_bad++; $display("FAIL abort_rk_data: got %h want 0", ifa.rk_data); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0; seen_busy = 0; seen_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.done) seen_done++;
      if (ifa.busy) seen_busy++;
      if (ifa.rk_valid) seen_valid++;
    end
    n_cmp++; if (seen_done + seen_busy + seen_valid != 0) begin n_bad++; $display("FAIL abort_quiet: got done=%0d busy=%0d valid=%0d want 0", seen_done, seen_busy, seen_valid); end

    build_model(2'b00, KEY128);
    run_key(2'b00, KEY128, 1'b0, 1'b0);
    n_cmp++; if (n_hs != 11) begin n_bad++; $display("FAIL restart_count: got %0d want 11", n_hs); end
    for (int r = 0; r <= 10; r++) begin
      n_cmp++; if (got_rk[r] !== exp_rk[r]) begin n_bad++; $display("FAIL restart_rk[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]); end
    end
    n_cmp++; if (done_n != 45) begin n_bad++; $display("FAIL restart_done_time: got T%0d want T45", done_n); end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.key_len = 2'b00; ifa.cipher_key = '0; ifa.rk_ready = 1'b1;
    ifb.start = 1'b0; ifb.key_len = 2'b00; ifb.cipher_key = '0; ifb.rk_ready = 1'b1;
    test_reset();
    test_key128();
    test_key192();
    test_key256();
    test_backpressure();
    test_start_ignored();
    test_err();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key-schedule generator. It supports 128-, 192- and 256-bit keys, selected at runtime, with the maximum key size bounded by a parameter.
- It streams round keys 0..Nr to the round datapath over a valid/ready handshake, one 32-bit word generated per cycle.
- It replaces the fixed-256-bit, precompute-all key schedule. Cipher cores of any key size share it.

Parameters:
- KEY_MAX, 256, largest key size supported (128, 192 or 256). A key_len above it is an error.
- RK_IDX_W, 4, width of rk_index.

Ports:
- Clk  input  1  clock. Rising edge.
- Rst  input  1  asynchronous, active-high reset.
- start  input  1  begin an expansion. Sampled only in IDLE.
- key_len  input  2  key size: 00 = 128 (Nk=4, Nr=10), 01 = 192 (Nk=6, Nr=12), 10 = 256 (Nk=8, Nr=14), 11 = reserved.
- cipher_key  input  256  key. Byte i is at [8i+7:8i]. A 128-bit key uses [127:0]; a 192-bit key uses [191:0]. Unused bits are ignored.
- rk_data  output  128  round key, same byte ordering.
- rk_index  output  RK_IDX_W  round number of rk_data.
- rk_valid  output  1  rk_data/rk_index valid.
- rk_ready  input  1  consumer accepts the current round key.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse after the final handshake.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs go to 0 and the FSM goes to IDLE. The window, assembly register, word counter and Rcon register are cleared. Rcon resets to 0x01.
- Rst asserted mid-expansion aborts immediately. No done pulse follows.
- States: IDLE, EXPAND, DRAIN, FINISH.
- IDLE:
  - start with a valid key_len (≤ KEY_MAX): latch cipher_key into the 8-word window, set i=0, busy=1, go to EXPAND.
  - start with key_len = 11 or > KEY_MAX: err=1 for one cycle and stay in IDLE.
- EXPAND, one word per edge unless stalled:
  - i < Nk: w[i] = key word i.
  - else, with temp = w[i-1]:
    - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {24'h0, Rcon}, then Rcon = xtime(Rcon).
    - else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
    - then w[i] = w[i-Nk] ^ temp.
  - SubWord uses four instances of the team's forward S-box.
  - Each word shifts into the window and into the 4-word assembly register.
- Assembly full (4 words): transfer to the output register if rk_valid == 0 or the handshake completes in the same cycle. Otherwise hold the new word back (stall, i unchanged) until the output frees.
- Handshake: a round key is accepted on an edge with rk_valid && rk_ready. rk_valid never drops and rk_data never changes until accepted.
- Timing:
  - start sampled at edge T0 puts w0..w3 on T1..T4 and makes rk0 valid after T4.
  - With rk_ready held high, round key r is valid after edge T4(r+1).
  - The last word is i = 4(Nr+1)-1: 43, 51 or 59.
- After the final word, go to DRAIN. When round key Nr is accepted, go to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored. key_len and cipher_key are don't-care after the T0 sample.
- rk_index increments on each accepted handshake and resets to 0 at start.
- Rcon uses xtime with 0x1b reduction. Uses: 0x01..0x36 for 128 (10 uses), 8 uses for 192, 7 uses for 256.

Optional Feature:
- AES_KEY_ZEROIZE_EN defined:
  - On the FINISH cycle, the window, assembly and output registers are cleared to 0.
  - rk_data is forced to 0 whenever rk_valid == 0.
- Undefined: registers keep their last values after done, and rk_data holds the last round key.

Test Plan:
- 128-bit key 0x0f0e0d0c0b0a09080706050403020100, key_len=00, rk_ready=1 -> rk0 = key after T4. rk1 = 0xfe76abd6f178a6dafa72afd2fd74aad6. rk10 = 0xc5302b4d8ba707f3174a94e37f1d1113 after T44. done one cycle after the rk10 handshake.
- 192-bit key bytes 00..17, key_len=01 -> 13 round keys. rk12 = 0x5d1da4e371c218c409dc781a330a97a4. rk_index runs 0..12.
- 256-bit key 0x1f1e..0100, key_len=10 -> 15 round keys. rk14 = 0x36de686d3cc21a37e97909bfcc79fc24.
- rk_ready toggled pseudo-randomly during a 256-bit run -> identical key sequence. rk_data stays stable while valid && !ready. No round key dropped or duplicated.
- key_len=11, or key_len=10 with KEY_MAX=128 -> err pulse, busy stays 0, rk_valid never asserts. Also: start asserted mid-expansion is ignored.
- Rst pulsed after rk3 -> all outputs 0 asynchronously, no done. A fresh start then reproduces the full correct sequence.
